sqrt_iter: RTL
==============

# sqrt_iter

Iterative, parametrised integer/fixed-point square-root unit with valid/ready handshakes on both sides and a configurable number of root bits resolved per clock. It is the next-generation replacement for the single-bit-per-cycle root block. It sits behind producers that supply radicands and ahead of consumers that may apply backpressure. Throughput and area trade off through `STEPS`; results can optionally be rounded to nearest.

## Interface
- `WIDTH`, 8 — radicand, root and remainder width; must be ≥ 4.
- `FBITS`, 0 — fractional bits of the radicand.
  - Requires `0 ≤ FBITS ≤ WIDTH-2`.
  - `WIDTH+FBITS` must be even.
- `STEPS`, 1 — root bits resolved per clock; must divide `ITER = (WIDTH+FBITS)/2`.

- `clk` input 1 — clock; all state changes on the rising edge.
- `rst` input 1 — asynchronous, active-high reset.
- `in_valid` input 1 — radicand offered.
- `in_ready` output 1 — unit can accept a radicand.
- `rad` input WIDTH — radicand; sampled only on the accept edge.
- `busy` output 1 — calculation in progress (state CALC).
- `out_valid` output 1 — `root`, `rem` and `rnd_up` are valid.
- `out_ready` input 1 — consumer accepts the result.
- `root` output WIDTH — root, zero-extended; holds `ITER` significant bits plus a possible rounding carry.
- `rem` output WIDTH — remainder of the truncated root.
- `rnd_up` output 1 — root was incremented by rounding.

## Operation
- States and transitions:
  - IDLE → CALC on accept (`in_valid && in_ready`).
  - CALC → DONE after `ITER/STEPS` cycles.
  - DONE → IDLE on `out_ready`.
- `in_ready` is 1 only in IDLE. `busy` is 1 only in CALC. `out_valid` is 1 only in DONE.
- Accept edge:
  - Clears the counter, partial root and accumulator.
  - Loads the radicand copy with `rad`, shifted left by `FBITS` (i.e. the computation uses `rad * 2^FBITS`).
- Each CALC cycle performs `STEPS` chained restoring steps combinationally. One step:
  - Shift the next 2 radicand bits into the accumulator (`WIDTH+2` bits).
  - Compute `t = acc − {q,01}`.
  - If `t ≥ 0` (MSB clear): `acc = t` and `q = {q,1}`.
  - Otherwise: `q = {q,0}`.
- Truncated result (no rounding):
  - `root = floor(sqrt(rad·2^FBITS))`.
  - `rem = rad·2^FBITS − root²`.
  - `0 ≤ rem ≤ 2·root`.
- Outputs are registered at CALC→DONE and held stable throughout DONE, whatever `in_valid` does.
- `in_valid` asserted outside IDLE is ignored. There is no queuing; the producer holds `rad` until accepted.
- Reset mid-operation: the calculation is abandoned and the unit returns to IDLE; no result is produced.

## Timing
- Reset values:
  - State = IDLE.
  - `in_ready` = 1.
  - `busy` = 0.
  - `out_valid` = 0.
  - `root` = 0, `rem` = 0, `rnd_up` = 0.
- Latency:
  - Accept on edge N.
  - `out_valid` rises after edge N + `ITER/STEPS`.
  - Example: `WIDTH=8`, `STEPS=1` gives 4 cycles; `STEPS=2` gives 2; `STEPS=4` gives 1.
- Result handoff on edge M, with `out_valid && out_ready` true at M:
  - After M: `out_valid` = 0 and `in_ready` = 1.
  - The next accept can occur no earlier than edge M+1.
- Sustained throughput: one result per `ITER/STEPS + 2` cycles with `out_ready` tied high.
- `out_ready` held low keeps DONE indefinitely; outputs do not change.
- No combinational path from `in_valid`/`out_ready` to `in_ready`/`out_valid`.

## Configuration
- `SQRT_ROUND_EN` defined: round to nearest at the CALC→DONE transition.
  - If `rem > root` (truncated): `root = root+1` and `rnd_up = 1`.
  - Otherwise `root` is unchanged and `rnd_up = 0`.
  - `rem` always reports the truncated remainder.
  - Adds one `ITER`-bit comparator and incrementer; latency is unchanged.
- Not defined: `root` is the truncated root, `rnd_up` is tied 0, and the rounding logic is absent.

## Test plan
- `WIDTH=8`, `FBITS=0`, `STEPS=1`:
  - `rad=232` → after 4 cycles `root=15`, `rem=7`, `rnd_up=0`.
  - `rad=0` → `root=0`, `rem=0`.
- Rounding boundary (`WIDTH=8`, `FBITS=0`, `SQRT_ROUND_EN`):
  - `rad=240` → `root=15`, `rem=15`, `rnd_up=0`.
  - `rad=241` → `root=16`, `rem=16`, `rnd_up=1`.
  - `rad=255` → `root=16`, `rem=30`, `rnd_up=1`.
  - Without the macro: `rad=255` → `root=15`.
- Fixed point (`WIDTH=8`, `FBITS=4`, `STEPS=2`):
  - `rad=0x20` (2.0) → 3 cycles later `root=22`, `rem=28`.
  - With `SQRT_ROUND_EN`: `root=23`, `rnd_up=1`.
- Backpressure:
  - Hold `out_ready=0` for 10 cycles after `out_valid` while toggling `in_valid` and `rad`.
  - Required: outputs stable, `in_ready=0`, no new accept.
  - Then `out_ready=1` → IDLE on the next edge.
- Reset mid-CALC:
  - Assert `rst` asynchronously 2 cycles after accepting `rad=200`.
  - Required: all outputs at reset values immediately; no `out_valid` afterwards.
  - A fresh `rad=144` afterwards yields `root=12`, `rem=0`.
- Exhaustive sweep (`WIDTH=8`, all `STEPS` ∈ {1,2,4}):
  - All 256 radicands back-to-back, with random `out_ready`.
  - Each result matches the floor-sqrt reference.
  - `rem ≤ 2·root` holds for every result.
  - Latency equals `ITER/STEPS`.

Source files
------------

// File: rtl/sqrt_iter_if.sv
// sqrt_iter_if: handshake bundle for the iterative square-root unit.
// Producer side (in_valid/in_ready/rad) and consumer side
// (out_valid/out_ready/root/rem/rnd_up) share one interface.
// The master modport is the environment; the slave modport is the unit.
interface sqrt_iter_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] rad;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] root;
  logic [WIDTH-1:0] rem;
  logic             rnd_up;

  modport master (
    output in_valid, rad, out_ready,
    input  in_ready, busy, out_valid, root, rem, rnd_up
  );

  modport slave (
    input  in_valid, rad, out_ready,
    output in_ready, busy, out_valid, root, rem, rnd_up
  );
endinterface

// File: rtl/sqrt_iter.sv
// sqrt_iter: iterative restoring square root, STEPS root bits per clock.
// root = floor(sqrt(rad * 2^FBITS)), rem = rad * 2^FBITS - root^2.
// Optional feature macro: SQRT_ROUND_EN -- round the root to nearest
// (root+1 when rem > root) and flag it on rnd_up; rem stays truncated.
module sqrt_iter #(
  parameter int WIDTH = 8,
  parameter int FBITS = 0,
  parameter int STEPS = 1
) (
  input  logic       clk,
  input  logic       rst,
  sqrt_iter_if.slave bus
);

  localparam int ITER = (WIDTH + FBITS) / 2;      // root bits
  localparam int RW   = WIDTH + FBITS;            // scaled radicand width
  localparam int AW   = WIDTH + 2;                // accumulator width
  localparam int NCYC = ITER / STEPS;             // CALC cycles
  localparam int CW   = $clog2(NCYC + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  if (WIDTH < 4 || FBITS < 0 || FBITS > WIDTH - 2 || ((WIDTH + FBITS) % 2) != 0 ||
      STEPS < 1 || (ITER % STEPS) != 0) begin : g_bad_params
    $error("sqrt_iter: illegal WIDTH/FBITS/STEPS combination");
  end

  logic [1:0]       state_r;
  logic [CW-1:0]    cnt_r;
  logic [AW-1:0]    acc_r;
  logic [ITER-1:0]  q_r;
  logic [RW-1:0]    radc_r;
  logic             in_ready_r;
  logic             busy_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] root_r;
  logic [WIDTH-1:0] rem_r;
  logic             rnd_up_r;

  logic [AW-1:0]    acc_s;
  logic [ITER-1:0]  q_s;
  logic [RW-1:0]    radc_s;

  // STEPS chained restoring steps: bring in two radicand bits, trial-subtract
  // {q,01}, keep the difference and append 1 when it does not go negative.
  function automatic logic [AW+ITER+RW-1:0] root_steps(
    input logic [AW-1:0]   acc_i,
    input logic [ITER-1:0] q_i,
    input logic [RW-1:0]   rc_i
  );
    logic [AW-1:0]   acc;
    logic [ITER-1:0] q;
    logic [RW-1:0]   rc;
    logic [AW-1:0]   sh;
    logic [AW-1:0]   tr;
    acc = acc_i;
    q   = q_i;
    rc  = rc_i;
    for (int i = 0; i < STEPS; i++) begin
      sh = {acc[AW-3:0], rc[RW-1 -: 2]};
      tr = sh - AW'({q, 2'b01});
      rc = {rc[RW-3:0], 2'b00};
      if (!tr[AW-1]) begin
        acc = tr;
        q   = {q[ITER-2:0], 1'b1};
      end else begin
        acc = sh;
        q   = {q[ITER-2:0], 1'b0};
      end
    end
    return {acc, q, rc};
  endfunction

  assign {acc_s, q_s, radc_s} = root_steps(acc_r, q_r, radc_r);

`ifdef SQRT_ROUND_EN
  // Round to nearest: the true root lies above root+0.5 exactly when rem > root.
  logic rnd_s;
  assign rnd_s = (acc_s[WIDTH-1:0] > WIDTH'(q_s));
`endif

  // Control FSM, datapath registers and registered result/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      acc_r       <= '0;
      q_r         <= '0;
      radc_r      <= '0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
      root_r      <= '0;
      rem_r       <= '0;
      rnd_up_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.in_valid) begin
            state_r    <= ST_CALC;
            cnt_r      <= '0;
            acc_r      <= '0;
            q_r        <= '0;
            radc_r     <= RW'(bus.rad) << FBITS;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        ST_CALC: begin
          acc_r  <= acc_s;
          q_r    <= q_s;
          radc_r <= radc_s;
          cnt_r  <= cnt_r + CW'(1);
          if (cnt_r == CW'(NCYC - 1)) begin
            state_r     <= ST_DONE;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b1;
            rem_r       <= acc_s[WIDTH-1:0];
`ifdef SQRT_ROUND_EN
            root_r      <= WIDTH'(q_s) + WIDTH'(rnd_s);
            rnd_up_r    <= rnd_s;
`else
            root_r      <= WIDTH'(q_s);
            rnd_up_r    <= 1'b0;
`endif
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          in_ready_r  <= 1'b1;
          busy_r      <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.busy      = busy_r;
  assign bus.out_valid = out_valid_r;
  assign bus.root      = root_r;
  assign bus.rem       = rem_r;
  assign bus.rnd_up    = rnd_up_r;

endmodule
